// File: rtl/multiport_register_file.sv
// Scalar register file: N read ports, one bypassed write port,
// per-register pending bits and a self-clearing sequencer.
module multiport_register_file #(
    parameter int DATA_W   = 36,
    parameter int DEPTH    = 32,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_RD*AW-1:0]     rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_pend,
    input  logic                     we,
    input  logic [AW-1:0]            wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     rsv_valid,
    input  logic [AW-1:0]            rsv_addr,
    input  logic                     clr_req,
    output logic                     ready
);

    typedef enum logic {
        CLEAR,
        READY
    } state_t;

    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    state_t              state;
    logic [AW-1:0]       clr_idx;
    logic [DEPTH-1:0]    pend;
    logic [DATA_W-1:0]   mem [DEPTH];

    logic is_ready;
    logic wr_ok;
    logic rsv_ok;

    assign is_ready = (state == READY);
    assign wr_ok    = we && !((ZERO_REG != 0) && (wr_addr == '0));
    assign rsv_ok   = rsv_valid && !((ZERO_REG != 0) && (rsv_addr == '0));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= CLEAR;
            clr_idx <= '0;
            pend    <= '0;
            ready   <= 1'b0;
        end else if (state == CLEAR) begin
            clr_idx <= clr_idx + 1'b1;
            if (clr_idx == LAST_IDX) begin
                state <= READY;
                ready <= 1'b1;
            end
        end else if (clr_req) begin
            state   <= CLEAR;
            clr_idx <= '0;
            pend    <= '0;
            ready   <= 1'b0;
        end else begin
            // reserve is applied last so it wins over a same-cycle writeback
            if (wr_ok)
                pend[wr_addr] <= 1'b0;
            if (rsv_ok)
                pend[rsv_addr] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (state == CLEAR)
                mem[clr_idx] <= '0;
            else if (!clr_req && wr_ok)
                mem[wr_addr] <= wr_data;
        end
    end

    for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
        logic [AW-1:0] a;
        logic          z;
        logic          byp;

        assign a   = rd_addr[g*AW +: AW];
        assign z   = (ZERO_REG != 0) && (a == '0);
        assign byp = is_ready && we && (a == wr_addr);

        assign rd_data[g*DATA_W +: DATA_W] =
            (!is_ready || z) ? '0 :
            byp              ? wr_data :
                               mem[a];
        assign rd_pend[g] = is_ready && !z && !byp && pend[a];
    end

endmodule

// File: tb/tb_multiport_register_file.sv
// Directed bench for multiport_register_file: default config plus a
// 4-port, 64-bit, 16-deep, no-zero-register config.
module tb_multiport_register_file;

    logic clk;
    int vectors;
    int miscompares;

    // default instance: DATA_W=36, DEPTH=32, NUM_RD=2, ZERO_REG=1
    logic        rst_n;
    logic [9:0]  rd_addr;
    logic [71:0] rd_data;
    logic [1:0]  rd_pend;
    logic        we;
    logic [4:0]  wr_addr;
    logic [35:0] wr_data;
    logic        rsv_valid;
    logic [4:0]  rsv_addr;
    logic        clr_req;
    logic        ready;

    // second instance: DATA_W=64, DEPTH=16, NUM_RD=4, ZERO_REG=0
    logic         b_rst_n;
    logic [15:0]  b_rd_addr;
    logic [255:0] b_rd_data;
    logic [3:0]   b_rd_pend;
    logic         b_we;
    logic [3:0]   b_wr_addr;
    logic [63:0]  b_wr_data;
    logic         b_rsv_valid;
    logic [3:0]   b_rsv_addr;
    logic         b_clr_req;
    logic         b_ready;

    multiport_register_file dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_pend   (rd_pend),
        .we        (we),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rsv_valid (rsv_valid),
        .rsv_addr  (rsv_addr),
        .clr_req   (clr_req),
        .ready     (ready)
    );

    multiport_register_file #(
        .DATA_W   (64),
        .DEPTH    (16),
        .NUM_RD   (4),
        .ZERO_REG (0)
    ) dut_b (
        .clk       (clk),
        .rst_n     (b_rst_n),
        .rd_addr   (b_rd_addr),
        .rd_data   (b_rd_data),
        .rd_pend   (b_rd_pend),
        .we        (b_we),
        .wr_addr   (b_wr_addr),
        .wr_data   (b_wr_data),
        .rsv_valid (b_rsv_valid),
        .rsv_addr  (b_rsv_addr),
        .clr_req   (b_clr_req),
        .ready     (b_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        rd_addr     = '0;
        we          = 1'b0;
        wr_addr     = '0;
        wr_data     = '0;
        rsv_valid   = 1'b0;
        rsv_addr    = '0;
        clr_req     = 1'b0;
        b_rst_n     = 1'b0;
        b_rd_addr   = '0;
        b_we        = 1'b0;
        b_wr_addr   = '0;
        b_wr_data   = '0;
        b_rsv_valid = 1'b0;
        b_rsv_addr  = '0;
        b_clr_req   = 1'b0;

        // reset hold
        tick();
        tick();
        rd_addr = {5'd3, 5'd1};
        #1;
        chk("rst_ready", 64'(ready), 64'd0);
        chk("rst_data", 64'(rd_data[35:0]) | 64'(rd_data[71:36]), 64'd0);
        chk("rst_pend", 64'(rd_pend), 64'd0);

        // reset release: ready rises after edge 32
        rst_n = 1'b1;
        for (int e = 1; e <= 32; e++) begin
            tick();
            chk("clr_ready", 64'(ready), 64'(e == 32));
        end
        for (int r = 0; r < 32; r++) begin
            rd_addr = {5'(r), 5'(r)};
            #1;
            chk("init_d0", 64'(rd_data[35:0]), 64'd0);
            chk("init_d1", 64'(rd_data[71:36]), 64'd0);
            chk("init_p", 64'(rd_pend), 64'd0);
        end

        // write-through bypass
        we      = 1'b1;
        wr_addr = 5'd5;
        wr_data = 36'hABCDE1234;
        rd_addr = {5'd6, 5'd5};
        #1;
        chk("byp_p0", 64'(rd_data[35:0]), 64'hABCDE1234);
        chk("byp_p1", 64'(rd_data[71:36]), 64'd0);
        tick();
        we = 1'b0;
        #1;
        chk("stor_p0", 64'(rd_data[35:0]), 64'hABCDE1234);

        // zero register
        we        = 1'b1;
        wr_addr   = 5'd0;
        wr_data   = 36'hFFFFFFFFF;
        rsv_valid = 1'b1;
        rsv_addr  = 5'd0;
        rd_addr   = {5'd0, 5'd0};
        #1;
        chk("z_byp_d", 64'(rd_data[35:0]), 64'd0);
        chk("z_byp_p", 64'(rd_pend), 64'd0);
        tick();
        we        = 1'b0;
        rsv_valid = 1'b0;
        #1;
        chk("z_d", 64'(rd_data[71:36]), 64'd0);
        chk("z_p", 64'(rd_pend), 64'd0);

        // reservation / writeback
        rsv_valid = 1'b1;
        rsv_addr  = 5'd7;
        rd_addr   = {5'd5, 5'd7};
        #1;
        chk("rsv_same", 64'(rd_pend[0]), 64'd0);
        tick();
        rsv_valid = 1'b0;
        #1;
        chk("rsv_next", 64'(rd_pend), 64'b01);
        we      = 1'b1;
        wr_addr = 5'd7;
        wr_data = 36'h1;
        #1;
        chk("wb_byp_p", 64'(rd_pend[0]), 64'd0);
        chk("wb_byp_d", 64'(rd_data[35:0]), 64'd1);
        tick();
        we = 1'b0;
        #1;
        chk("wb_p", 64'(rd_pend[0]), 64'd0);
        chk("wb_d", 64'(rd_data[35:0]), 64'd1);

        // write and reserve same register
        we        = 1'b1;
        wr_addr   = 5'd9;
        wr_data   = 36'h123456789;
        rsv_valid = 1'b1;
        rsv_addr  = 5'd9;
        tick();
        we        = 1'b0;
        rsv_valid = 1'b0;
        rd_addr   = {5'd9, 5'd9};
        #1;
        chk("wr_rsv_d", 64'(rd_data[71:36]), 64'h123456789);
        chk("wr_rsv_p", 64'(rd_pend), 64'b11);

        // load r1..r31, then clear on request
        for (int r = 1; r < 32; r++) begin
            we      = 1'b1;
            wr_addr = 5'(r);
            wr_data = 36'h800000000 | 36'(r);
            tick();
        end
        we      = 1'b0;
        rd_addr = {5'd31, 5'd3};
        #1;
        chk("load_r3", 64'(rd_data[35:0]), 64'h800000003);
        chk("load_r31", 64'(rd_data[71:36]), 64'h80000001F);
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        chk("cr_ready", 64'(ready), 64'd0);
        we        = 1'b1;
        wr_addr   = 5'd3;
        wr_data   = 36'h5;
        rsv_valid = 1'b1;
        rsv_addr  = 5'd4;
        for (int e = 2; e <= 33; e++) begin
            tick();
            chk("cr_wait", 64'(ready), 64'(e == 33));
            if (e == 33) begin
                we        = 1'b0;
                rsv_valid = 1'b0;
            end
        end
        for (int r = 0; r < 32; r++) begin
            rd_addr = {5'(r), 5'(r)};
            #1;
            chk("cr_d", 64'(rd_data[35:0]), 64'd0);
            chk("cr_p", 64'(rd_pend), 64'd0);
        end

        // reset in mid-clear at clr_idx=10
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        repeat (10) tick();
        rst_n = 1'b0;
        tick();
        chk("mid_rst", 64'(ready), 64'd0);
        rst_n = 1'b1;
        for (int e = 1; e <= 32; e++) begin
            tick();
            chk("mid_clr", 64'(ready), 64'(e == 32));
        end

        // second instance
        b_rst_n = 1'b0;
        tick();
        b_rst_n = 1'b1;
        for (int e = 1; e <= 16; e++) begin
            tick();
            chk("b_clr", 64'(b_ready), 64'(e == 16));
        end
        b_we        = 1'b1;
        b_wr_addr   = 4'd0;
        b_wr_data   = 64'hFFFFFFFFF;
        b_rsv_valid = 1'b1;
        b_rsv_addr  = 4'd0;
        tick();
        b_rsv_valid = 1'b0;
        b_wr_addr   = 4'd2;
        b_wr_data   = 64'hDEADBEEF00000002;
        tick();
        b_wr_addr = 4'd5;
        b_wr_data = 64'h0123456789ABCDEF;
        b_rd_addr = {4'd5, 4'd2, 4'd5, 4'd0};
        #1;
        chk("b_p0_d", b_rd_data[63:0], 64'hFFFFFFFFF);
        chk("b_p1_d", b_rd_data[127:64], 64'h0123456789ABCDEF);
        chk("b_p2_d", b_rd_data[191:128], 64'hDEADBEEF00000002);
        chk("b_p3_d", b_rd_data[255:192], 64'h0123456789ABCDEF);
        chk("b_pend", 64'(b_rd_pend), 64'b0001);
        tick();
        b_we      = 1'b0;
        b_rd_addr = {4'd0, 4'd5, 4'd1, 4'd5};
        #1;
        chk("b_st_p0", b_rd_data[63:0], 64'h0123456789ABCDEF);
        chk("b_st_p1", b_rd_data[127:64], 64'd0);
        chk("b_st_p3", b_rd_data[255:192], 64'hFFFFFFFFF);
        chk("b_st_pd", 64'(b_rd_pend), 64'b1000);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/multiport_register_file.md
# multiport_register_file

Parametrised scalar register file with configurable data width, depth and read-port count. It has one write port with same-cycle write-through bypass and an optional hardwired zero register. A built-in clear sequencer zeroes every entry after reset or on request. Each register also carries a pending (scoreboard) bit that is set on reservation and cleared on writeback. It sits in the scalar pipeline between decode (reads, reservations) and writeback (writes).

## Interface
- DATA_W, 36, register width in bits
- DEPTH, 32, number of registers; power of two, ≥ 2
- NUM_RD, 2, number of read ports, 1–4
- ZERO_REG, 1, 1 = register 0 always reads 0, ignores writes and never goes pending
- AW, $clog2(DEPTH), address width (derived, not overridden)

- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  synchronous, active-low reset
- rd_addr  input  NUM_RD*AW  read addresses; port i = bits [i*AW +: AW]
- rd_data  output  NUM_RD*DATA_W  read data; port i = bits [i*DATA_W +: DATA_W]
- rd_pend  output  NUM_RD  pending flag for the register on each read port
- we  input  1  write enable
- wr_addr  input  AW  write address
- wr_data  input  DATA_W  write data
- rsv_valid  input  1  reserve (mark pending) register rsv_addr
- rsv_addr  input  AW  register to reserve
- clr_req  input  1  start a clear sequence; honoured only while ready=1
- ready  output  1  1 = idle and usable; 0 = clear in progress

## Operation
- FSM states: CLEAR and READY.
- Reset (rst_n=0 at an edge): state←CLEAR, clr_idx←0, all pending bits←0, ready←0.
- CLEAR state, each edge with rst_n=1:
  - entry[clr_idx]←0, clr_idx←clr_idx+1.
  - When clr_idx==DEPTH-1, state←READY on that same edge.
  - we, rsv_valid and clr_req are ignored.
  - All rd_data read 0; all rd_pend read 0.
- READY state, clr_req=1: state←CLEAR, clr_idx←0, pending bits←0. A write or reservation in that same cycle is dropped.
- Write (READY, we=1): entry[wr_addr]←wr_data and pend[wr_addr]←0, except when ZERO_REG=1 and wr_addr=0 (the write is dropped).
- Reserve (READY, rsv_valid=1): pend[rsv_addr]←1, except when ZERO_REG=1 and rsv_addr=0.
- Write and reserve to the same address in one cycle: data is written and pend ends at 1 (reserve wins).
- Reads are combinational from current storage.
- Bypass: if READY, we=1 and rd_addr[i]==wr_addr (and the address is not the zero register), rd_data[i]=wr_data and rd_pend[i]=0 in that cycle.
- A reservation does not affect same-cycle rd_pend; it becomes visible the next cycle.
- ZERO_REG=1, rd_addr[i]=0: rd_data[i]=0, rd_pend[i]=0 unconditionally.
- Every read port behaves independently; any ports may use the same address.

## Timing
- Outputs held in reset: ready=0, rd_data=0, rd_pend=0.
- Clear latency: DEPTH edges with rst_n=1, counted from the first such edge. ready=1 is visible after edge DEPTH (for DEPTH=32, after the 32nd edge).
- Clear latency after clr_req: 1 edge to enter CLEAR, then DEPTH edges.
- Reset asserted mid-clear: restarts at clr_idx=0 and takes the full DEPTH edges again.
- Write-to-read latency: 0 cycles via bypass; from storage on the next cycle.
- Reserve-to-rd_pend latency: 1 cycle.
- Write-clear-to-rd_pend latency: 0 cycles via bypass; the registered bit is cleared on the next cycle.
- clr_idx wraps or saturates only internally; it is never observable.

## Test plan
- Reset release, DEPTH=32: ready=0 for 32 edges, then 1. All 32 registers read 0 and rd_pend=0 on both ports.
- Write 36'hABCDE1234 to r5 while reading r5 on port 0 and r6 on port 1: same cycle gives port0=36'hABCDE1234, port1=0. Next cycle port0 still reads 36'hABCDE1234.
- ZERO_REG=1: write 36'hFFFFFFFFF to r0 and reserve r0 -> r0 reads 0 and rd_pend=0. Repeat with ZERO_REG=0 -> reads 36'hFFFFFFFFF.
- Reserve r7 -> rd_pend=1 on the next cycle. Write r7=36'h1 -> rd_pend=0 in that same cycle (bypass). Write and reserve r9 in one cycle -> rd_pend(r9)=1 next cycle and data updated.
- After loading r1..r31 with nonzero values, pulse clr_req: ready=0 for 33 edges (1 + 32), writes during that window are dropped, then all registers read 0.
- Assert rst_n=0 at clr_idx=10 during a clear, then release -> a full 32-edge clear with ready=0 throughout. Repeat with NUM_RD=4, DATA_W=64, DEPTH=16 -> 16-edge clear and independent bypass on all four ports.
